// File: rtl/temp_bcd_formatter.sv
// rtl/temp_bcd_formatter.sv - debounced ADT7420 13-bit word to sign + BCD digits
module temp_bcd_formatter #(
  parameter int STABLE_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] raw,
  output logic        sign,
  output logic [3:0]  bcd_hund,
  output logic [3:0]  bcd_tens,
  output logic [3:0]  bcd_ones,
  output logic [3:0]  bcd_tenth,
  output logic        valid,
  output logic        busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_CONV = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [12:0] last_raw_q, last_raw_d;
  logic [12:0] cand_q, cand_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  it_q, it_d;
  logic [20:0] shreg_q, shreg_d;
  logic        neg_q, neg_d;
  logic [3:0]  tenth_r_q, tenth_r_d;
  logic        sign_q, sign_d;
  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  tenth_q, tenth_d;
  logic        valid_q, valid_d;

  logic [12:0] temp_in;
  logic [13:0] cand_ext;
  logic [13:0] mag;
  logic [7:0]  frac_x10;
  logic [20:0] adj;
  logic        unused_bits;

  assign temp_in     = raw[15:3];
  assign unused_bits = ^{raw[2:0], mag[13], frac_x10[3:0]};

  // Double-dabble correction: a BCD nibble of 5 or more gets +3 before the shift
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Magnitude of the candidate in 14 bits so -4096 maps cleanly to 4096
  always_comb begin
    cand_ext = {cand_q[12], cand_q};
    mag      = cand_q[12] ? (~cand_ext + 14'd1) : cand_ext;
    frac_x10 = {4'b0, mag[3:0]} * 8'd10;
    adj      = {add3(shreg_q[20:17]), add3(shreg_q[16:13]), add3(shreg_q[12:9]), shreg_q[8:0]};
  end

  // Next-state: stability wait, load, one shift per clock, publish results
  always_comb begin
    state_d   = state_q;
    last_raw_d = last_raw_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    it_d      = it_q;
    shreg_d   = shreg_q;
    neg_d     = neg_q;
    tenth_r_d = tenth_r_q;
    sign_d    = sign_q;
    hund_d    = hund_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    tenth_d   = tenth_q;
    valid_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (temp_in != last_raw_q) begin
          cand_d  = temp_in;
          cnt_d   = 8'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (temp_in != cand_q) begin
          cand_d = temp_in;
          cnt_d  = 8'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_LOAD: begin
        neg_d     = cand_q[12];
        tenth_r_d = frac_x10[7:4];
        shreg_d   = {12'b0, mag[12:4]};
        it_d      = 4'd0;
        state_d   = S_CONV;
      end
      S_CONV: begin
        shreg_d = {adj[19:0], 1'b0};
        it_d    = it_q + 4'd1;
        if (it_q == 4'd8) state_d = S_DONE;
      end
      S_DONE: begin
        sign_d     = neg_q;
        hund_d     = shreg_q[20:17];
        tens_d     = shreg_q[16:13];
        ones_d     = shreg_q[12:9];
        tenth_d    = tenth_r_q;
        valid_d    = 1'b1;
        last_raw_d = cand_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      last_raw_q <= 13'd0;
      cand_q     <= 13'd0;
      cnt_q      <= 8'd0;
      it_q       <= 4'd0;
      shreg_q    <= 21'd0;
      neg_q      <= 1'b0;
      tenth_r_q  <= 4'd0;
      sign_q     <= 1'b0;
      hund_q     <= 4'd0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      tenth_q    <= 4'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_raw_q <= last_raw_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      it_q       <= it_d;
      shreg_q    <= shreg_d;
      neg_q      <= neg_d;
      tenth_r_q  <= tenth_r_d;
      sign_q     <= sign_d;
      hund_q     <= hund_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      tenth_q    <= tenth_d;
      valid_q    <= valid_d;
    end
  end

  assign sign      = sign_q;
  assign bcd_hund  = hund_q;
  assign bcd_tens  = tens_q;
  assign bcd_ones  = ones_q;
  assign bcd_tenth = tenth_q;
  assign valid     = valid_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_temp_bcd_formatter.sv
// tb/tb_temp_bcd_formatter.sv - directed bench for temp_bcd_formatter
module tb_temp_bcd_formatter;

  localparam int S   = 64;
  localparam int LAT = S + 12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] raw = 16'h0000;
  logic        sign, valid, busy;
  logic [3:0]  bcd_hund, bcd_tens, bcd_ones, bcd_tenth;

  int checks = 0;
  int passes = 0;

  temp_bcd_formatter #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .raw(raw), .sign(sign),
    .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .bcd_tenth(bcd_tenth), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] raw;
    int s, h, t, o, f;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int packed_out();
    return int'({sign, bcd_hund, bcd_tens, bcd_ones, bcd_tenth});
  endfunction

  function automatic int digits(input int s, input int h, input int t, input int o, input int f);
    return (s << 16) | (h << 12) | (t << 8) | (o << 4) | f;
  endfunction

  // Waits for a valid pulse; cycles = -1 on timeout, held = 0 if outputs moved early
  task automatic wait_valid(input int limit, output int cycles, output int held);
    int snap;
    snap   = packed_out();
    held   = 1;
    cycles = 0;
    while (cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (valid) break;
      if (packed_out() != snap) held = 0;
    end
    if (!valid) cycles = -1;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int c, h;
    @(negedge clk);
    raw = v.raw;
    wait_valid(LAT + 40, c, h);
    check({name, " latency"}, c, LAT);
    check({name, " hold"}, h, 1);
    check({name, " digits"}, packed_out(), digits(v.s, v.h, v.t, v.o, v.f));
    @(negedge clk);
    check({name, " pulse"}, int'(valid), 0);
    check({name, " idle"}, int'(busy), 0);
  endtask

  initial begin
    int c, h, pulses, lat, cap, vcount, bcount;
    int bits[5];
    vec_t tmp;

    vecs[0] = '{16'h0C80, 0, 0, 2, 5, 0};
    vecs[1] = '{16'hFAC0, 1, 0, 1, 0, 5};
    vecs[2] = '{16'hFFF8, 1, 0, 0, 0, 0};
    vecs[3] = '{16'h8000, 1, 2, 5, 6, 0};
    vecs[4] = '{16'h7FF8, 0, 2, 5, 5, 9};
    vecs[5] = '{16'h0C80, 0, 0, 2, 5, 0};
    bits = '{3, 5, 8, 10, 11};

    // Reset state and all-zero input after release
    repeat (3) @(negedge clk);
    check("rst outputs", packed_out(), 0);
    check("rst valid", int'(valid), 0);
    check("rst busy", int'(busy), 0);
    reset = 1'b1;
    vcount = 0;
    bcount = 0;
    repeat (200) begin
      @(negedge clk);
      if (valid) vcount++;
      if (busy) bcount++;
    end
    check("zero valid", vcount, 0);
    check("zero busy", bcount, 0);
    check("zero outputs", packed_out(), 0);

    // Table of steady conversions
    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Flag-only change never starts a conversion
    @(negedge clk);
    raw = 16'h0C87;
    vcount = 0;
    repeat (100) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("flag valid", vcount, 0);

    // Change during CONV: current result first, then the new value
    tmp = '{16'hFAC0, 1, 0, 1, 0, 5};
    run_vec(tmp, "pre");
    @(negedge clk);
    raw = 16'h0C80;
    repeat (S + 5) @(negedge clk);
    check("mid busy", int'(busy), 1);
    raw = 16'h0D28;
    wait_valid(LAT + 40, c, h);
    check("mid lat1", c, LAT - (S + 5));
    check("mid dig1", packed_out(), digits(0, 0, 2, 5, 0));
    wait_valid(LAT + 40, c, h);
    check("mid lat2", c, LAT);
    check("mid dig2", packed_out(), digits(0, 0, 2, 6, 3));

    // Reset during CONV clears outputs at once, then a fresh conversion
    @(negedge clk);
    raw = 16'h0C80;
    repeat (S + 5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort outputs", packed_out(), 0);
    check("abort valid", int'(valid), 0);
    check("abort busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_valid(LAT + 40, c, h);
    check("fresh lat", c, LAT);
    check("fresh hold", h, 1);
    check("fresh dig", packed_out(), digits(0, 0, 2, 5, 0));

    // Bit-by-bit walk 0x0000 -> 0x0D28 gives exactly one pulse
    @(negedge clk);
    reset = 1'b0;
    raw = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    lat = -1;
    cap = 0;
    for (int b = 0; b < 5; b++) begin
      raw[bits[b]] = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (valid) pulses++;
      end
    end
    c = 4;
    while (c < LAT + 30) begin
      @(negedge clk);
      c++;
      if (valid) begin
        pulses++;
        lat = c;
        cap = packed_out();
      end
    end
    check("walk pulses", pulses, 1);
    check("walk lat", lat, LAT);
    check("walk dig", cap, digits(0, 0, 2, 6, 3));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
